// File: rtl/lsu.sv
// lsu -- load/store unit for the RV32I core.
//
// Takes one memory instruction from the decoder, runs it over a
// single-outstanding req/gnt/rvalid data bus, and returns the aligned,
// extended load result. The pipeline is stalled until the access retires.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_lsu_valid           memory instruction present
//   i_st_mem              1 = store, 0 = load
//   i_funct3              access size / signedness
//   i_addr, i_st_data     effective address, store data (rs2)
//   o_stall               hold PC and pipeline
//   o_done                pulse: access retired, o_ld_data valid
//   o_ld_data             extended load result (held until next load)
//   o_misalign            pulse: misaligned address or illegal funct3
//   o_bus_err             pulse: bus timeout
//   o_mem_*/i_mem_*       data-memory request/grant/response bus
module lsu #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_valid,
  input  logic        i_st_mem,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  state_t          state_q, state_d;
  logic            st_mem_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            bus_err_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     mem_addr_q;
  logic [3:0]      mem_be_q;
  logic            mem_we_q;
  logic [31:0]     mem_wdata_q;
  logic [31:0]     ld_data_q;
  logic            timeout;
  logic            accept;

  function automatic logic is_misalign(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (f3[1:0] == 2'b11 || f3 == 3'b110) bad = 1'b1;
    else if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
    else if (f3[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] rep_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic        [31:0] lane;
    logic signed [31:0] r;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  r = $signed(lane[7:0]);
      3'b001:  r = $signed(lane[15:0]);
      3'b100:  r = $signed({24'd0, lane[7:0]});
      3'b101:  r = $signed({16'd0, lane[15:0]});
      default: r = $signed(lane);
    endcase
    return r;
  endfunction

  assign accept  = (state_q == IDLE) && i_lsu_valid;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; gnt takes priority over rvalid while in REQ
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_lsu_valid) state_d = is_misalign(i_funct3, i_addr[1:0]) ? ERR : REQ;
      REQ:  if (i_mem_gnt) state_d = WAIT;
            else if (timeout) state_d = ERR;
      WAIT: if (i_mem_rvalid) state_d = DONE;
            else if (timeout) state_d = ERR;
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Captured request, bus drive registers, timeout counter, load result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_mem_q    <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      ld_data_q   <= 32'd0;
    end else begin
      if (accept) begin
        st_mem_q    <= i_st_mem;
        funct3_q    <= i_funct3;
        off_q       <= i_addr[1:0];
        bus_err_q   <= 1'b0;
        cnt_q       <= '0;
        mem_addr_q  <= {i_addr[31:2], 2'b00};
        mem_be_q    <= calc_be(i_funct3, i_addr[1:0]);
        mem_we_q    <= i_st_mem;
        mem_wdata_q <= rep_wdata(i_funct3, i_st_data);
      end
      if (state_q == REQ || state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
        if (state_d == ERR) bus_err_q <= 1'b1;
      end
      if (state_q == WAIT && i_mem_rvalid && !st_mem_q)
        ld_data_q <= ext_load(funct3_q, off_q, i_mem_rdata);
    end
  end

  // Output decode from state
  always_comb begin
    o_mem_req  = 1'b0;
    o_done     = 1'b0;
    o_misalign = 1'b0;
    o_bus_err  = 1'b0;
    o_stall    = 1'b0;
    case (state_q)
      IDLE: o_stall = i_lsu_valid && i_rst_n;
      REQ:  begin o_mem_req = 1'b1; o_stall = 1'b1; end
      WAIT: o_stall = 1'b1;
      DONE: o_done = 1'b1;
      ERR:  begin o_bus_err = bus_err_q; o_misalign = !bus_err_q; end
      default: ;
    endcase
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_ld_data   = ld_data_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, st_mem;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic        stall, done, misalign, bus_err;
  logic [31:0] ld_data;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_valid(lsu_valid), .i_st_mem(st_mem),
    .i_funct3(funct3), .i_addr(addr), .i_st_data(st_data),
    .o_stall(stall), .o_done(done), .o_ld_data(ld_data),
    .o_misalign(misalign), .o_bus_err(bus_err),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    int          kind;   // 0 done, 1 misalign, 2 bus error
    logic [31:0] ld;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every retire/error pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (done || misalign || bus_err)) begin
      int   kind;
      exp_t e;
      kind = done ? 0 : (misalign ? 1 : 2);
      if (sbq.size() == 0) begin
        chk("sb_unexpected_event", kind, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("sb_kind", kind, e.kind);
        if (kind == 0) chk("sb_ld_data", ld_data, e.ld);
      end
    end
  end

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdv,
                              input int gd, input int rd, input logic mis,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] ld);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rdv;
    v.gd = gd; v.rd = rd; v.mis = mis; v.be = be; v.wdata = wd; v.ld = ld;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    lsu_valid = 1'b1; st_mem = v.st; funct3 = v.f3; addr = v.addr; st_data = v.sdata;
    e.kind = v.mis ? 1 : 0;
    e.ld   = v.ld;
    sbq.push_back(e);
    @(negedge clk);
    chk("stall_on_request", stall, 1);
    @(posedge clk); #1;
    if (v.mis) begin
      @(negedge clk);
      chk("misalign_no_req", mem_req, 0);
      chk("misalign_stall_released", stall, 0);
      @(posedge clk); #1;
      lsu_valid = 1'b0;
      return;
    end
    for (int k = 0; k < v.gd; k++) begin
      @(negedge clk);
      chk("req_held", mem_req, 1);
      chk("req_addr_stable", mem_addr, {v.addr[31:2], 2'b00});
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("req", mem_req, 1);
    chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
    chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
    chk("mem_we", mem_we, v.st);
    if (v.st) chk("mem_wdata", mem_wdata, v.wdata);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    for (int k = 0; k < v.rd; k++) begin
      @(negedge clk);
      chk("wait_stall", stall, 1);
      chk("wait_no_req", mem_req, 0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = v.rdata;
    @(negedge clk);
    chk("wait_stall_rsp", stall, 1);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_stall_released", stall, 0);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
  endtask

  initial begin
    int   cyc;
    exp_t e;

    rst_n = 1'b0; lsu_valid = 1'b0; st_mem = 1'b0; funct3 = 3'b000;
    addr = 32'd0; st_data = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    //     st  f3      addr          sdata         rdata         gd rd mis be       wdata         ld
    tbl[0]  = mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
    tbl[1]  = mk(0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
    tbl[2]  = mk(0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 0, 4'b1000, 32'h0,        32'h00000080);
    tbl[3]  = mk(1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        0, 1, 0, 4'b1100, 32'hABCDABCD, 32'h00000080);
    tbl[4]  = mk(0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[5]  = mk(0, 3'b001, 32'h002, 32'h0,        32'h80017FFF, 0, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001);
    tbl[6]  = mk(0, 3'b101, 32'h002, 32'h0,        32'h80017FFF, 0, 0, 0, 4'b1100, 32'h0,        32'h00008001);
    tbl[7]  = mk(1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1, 0, 0, 4'b0010, 32'hA5A5A5A5, 32'h00008001);
    tbl[8]  = mk(0, 3'b011, 32'h000, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[9]  = mk(0, 3'b001, 32'h003, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[10] = mk(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        0, 2, 0, 4'b1111, 32'hCAFEF00D, 32'h00008001);
    tbl[11] = mk(0, 3'b000, 32'h000, 32'h0,        32'h1234567F, 0, 0, 0, 4'b0001, 32'h0,        32'h0000007F);
    tbl[12] = mk(0, 3'b110, 32'h000, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[13] = mk(0, 3'b100, 32'h502, 32'h0,        32'h00C30000, 0, 0, 0, 4'b0100, 32'h0,        32'h000000C3);
    tbl[14] = mk(0, 3'b010, 32'h700, 32'h0,        32'h13579BDF, 3, 2, 0, 4'b1111, 32'h0,        32'h13579BDF);
    tbl[15] = mk(0, 3'b111, 32'h004, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);

    #1;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", {28'd0, mem_be}, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_misalign_buserr", {misalign, bus_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_txn(tbl[i]);

    // Timeout: grant immediately, never respond
    @(posedge clk); #1;
    lsu_valid = 1'b1; st_mem = 1'b0; funct3 = 3'b010; addr = 32'h800;
    e.kind = 2; e.ld = 32'h0;
    sbq.push_back(e);
    @(posedge clk); #1; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    cyc = 2;
    while (cyc < 20) begin
      @(negedge clk);
      if (bus_err) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk("timeout_cycle", cyc, 9);
    chk("timeout_no_req", mem_req, 0);
    chk("timeout_stall_released", stall, 0);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("timeout_back_idle", stall, 0);

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    lsu_valid = 1'b1; st_mem = 1'b0; funct3 = 3'b010; addr = 32'h900;
    @(posedge clk); #1; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    chk("pre_rst_wait_stall", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", mem_req, 0);
    chk("rst_async_stall", stall, 0);
    chk("rst_async_ld_data", ld_data, 0);
    lsu_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rvalid_no_done", done, 0);
    chk("stray_rvalid_stall", stall, 0);
    chk("stray_rvalid_ld_data", ld_data, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core, directly downstream of the instruction decoder. It accepts one memory instruction per request when the decoder raises its LSU request (`lsu_VALID`). It drives a single-outstanding request/grant/response data-memory bus with byte enables and lane-replicated store data. It returns aligned, sign- or zero-extended load data and stalls the pipeline until the access retires.

## Interface
- TIMEOUT_CYC, 1023: cycles allowed in REQ+WAIT before a bus error is raised; minimum 2.
- i_clk  in  1  core clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_lsu_valid  in  1  memory instruction present; decoder `lsu_VALID`.
- i_st_mem  in  1  1 = store, 0 = load.
- i_funct3  in  3  instruction bits [14:12].
- i_addr  in  32  effective address from the ALU.
- i_st_data  in  32  rs2 value.
- o_stall  out  1  hold PC and pipeline.
- o_done  out  1  one-cycle pulse: access retired.
- o_ld_data  out  32  extended load result, valid while o_done=1.
- o_misalign  out  1  one-cycle pulse: misaligned address or illegal funct3.
- o_bus_err  out  1  one-cycle pulse: timeout.
- o_mem_req  out  1  bus request.
- i_mem_gnt  in  1  request accepted.
- o_mem_we  out  1  write.
- o_mem_addr  out  32  word address, bits [1:0] always 0.
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_rvalid  in  1  response; read data valid or write acknowledge.
- i_mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE with i_lsu_valid=1:
  - Register st_mem, funct3, addr and st_data.
  - Go to ERR with cause misalign when any of these holds: funct3 ∈ {011, 110, 111}; halfword access with addr[0]=1; word access with addr[1:0]≠0.
  - Otherwise go to REQ.
- REQ: o_mem_req=1. Address, be, we and wdata are held stable from registered values. On i_mem_gnt go to WAIT.
- WAIT: on i_mem_rvalid go to DONE and register the extended load data.
  - Stores also wait for i_mem_rvalid as a write acknowledge.
  - i_mem_rvalid outside WAIT is ignored.
- DONE: o_done=1. Go to IDLE. i_lsu_valid is ignored here; it still reflects the retiring instruction.
- ERR: o_misalign=1 or o_bus_err=1 according to the cause. Go to IDLE. No bus transaction occurs for misalign.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYC-1 without the expected gnt/rvalid, go to ERR with cause bus error.
  - o_mem_req drops.
- Byte enables, with o = addr[1:0]:
  - byte: 4'b0001 << o
  - half: 4'b0011 << o
  - word: 4'b1111
  - Loads drive the same be.
- Store data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Load data: lane = rdata >> (8*o).
  - funct3 000 (lb): sign-extend bits [7:0].
  - funct3 100 (lbu): zero-extend bits [7:0].
  - funct3 001 (lh): sign-extend bits [15:0].
  - funct3 101 (lhu): zero-extend bits [15:0].
  - funct3 010 (lw): full word.
- o_ld_data holds its value until the next load retires. It is 0 after reset and is not updated by stores.
- o_stall = (IDLE & i_lsu_valid) | REQ | WAIT. It is 0 in DONE and ERR so the instruction retires.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs are 0, including o_mem_req, o_mem_addr, o_mem_be and o_ld_data.
  - An in-flight request is abandoned.
- Minimum latency: request seen in IDLE at cycle N; REQ at N+1 with same-cycle gnt; WAIT at N+2 with same-cycle rvalid; o_done at N+3, when o_stall=0.
- Misaligned access: ERR at N+1, with o_misalign and o_stall=0 in that cycle.
- Back-to-back: the next request is accepted at the earliest in the cycle after DONE/ERR.
- Gnt and rvalid in the same cycle while in REQ: treat as gnt only. rvalid is expected in WAIT.
- All bus outputs are registered or decoded from state; there is no combinational path from i_mem_* to o_mem_*.

## Test plan
- lw at 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF -> o_mem_addr 0x100, be 1111; o_done at N+3; o_ld_data 0xDEADBEEF.
- lb at 0x103, rdata 0x80FF_FFFF -> be 1000; o_ld_data 0xFFFFFF80. lbu at the same address -> 0x00000080.
- sh at 0x202, data 0x1234ABCD -> be 1100, we=1, wdata 0xABCDABCD; o_done after ack.
- lw at 0x101 -> no o_mem_req; o_misalign pulse at N+1; stall released.
- gnt withheld for 3 cycles -> o_mem_req held with stable address. Separately, no rvalid, TIMEOUT_CYC=8 -> o_bus_err pulse, then IDLE.
- i_rst_n low mid-WAIT -> o_mem_req and o_stall drop to 0 immediately; a later rvalid is ignored.
